// File: rtl/banco_regs_extensor.sv
// ID-stage register file (32 x 32, 2R/1W, reg 0 hardwired to zero) plus 16->32 sign extender.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module banco_regs_extensor #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IMM_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] r1,
  input  logic [ADDR_W-1:0] r2,
  input  logic [ADDR_W-1:0] r3,
  input  logic [DATA_W-1:0] dado_escrita,
  output logic [DATA_W-1:0] dado_lido1,
  output logic [DATA_W-1:0] dado_lido2,
  input  logic [IMM_W-1:0]  sinal16,
  output logic [DATA_W-1:0] sinal32
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_en;

  assign write_en = RegWrite && (r3 != '0);

  // Storage; entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[r3] <= dado_escrita;
    end
  end

  // Combinational read ports, forced to zero during reset and for index 0.
  always_comb begin
    dado_lido1 = '0;
    dado_lido2 = '0;
    if (reset_n) begin
      if (r1 != '0) dado_lido1 = regs[r1];
      if (r2 != '0) dado_lido2 = regs[r2];
`ifdef REGFILE_BYPASS_EN
      if (write_en && (r3 == r1)) dado_lido1 = dado_escrita;
      if (write_en && (r3 == r2)) dado_lido2 = dado_escrita;
`endif
    end
  end

  assign sinal32 = {{(DATA_W-IMM_W){sinal16[IMM_W-1]}}, sinal16};

endmodule

// File: tb/tb_banco_regs_extensor.sv
// Directed self-checking bench for banco_regs_extensor; expectations follow REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_banco_regs_extensor;

  logic        clock;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  r1, r2, r3;
  logic [31:0] dado_escrita;
  logic [31:0] dado_lido1, dado_lido2;
  logic [15:0] sinal16;
  logic [31:0] sinal32;

  int checks;
  int errors;

  banco_regs_extensor dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .RegWrite     (RegWrite),
    .r1           (r1),
    .r2           (r2),
    .r3           (r3),
    .dado_escrita (dado_escrita),
    .dado_lido1   (dado_lido1),
    .dado_lido2   (dado_lido2),
    .sinal16      (sinal16),
    .sinal32      (sinal32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    RegWrite = 1'b1; r3 = idx; dado_escrita = data;
    tick();
    RegWrite = 1'b0;
  endtask

  typedef struct { logic [15:0] in; logic [31:0] exp; } ext_vec_t;
  ext_vec_t ext_vecs [5];

  initial begin
    logic [31:0] same_cycle_exp;
    checks = 0; errors = 0;
    reset_n = 1'b0; RegWrite = 1'b1; r1 = 5'd3; r2 = 5'd3; r3 = 5'd3;
    dado_escrita = 32'hAAAA_5555; sinal16 = 16'h0000;

    // Writes during reset are ignored.
    tick(); tick();
    check("rst_wr_ignored", dado_lido1, 32'h0);
    RegWrite = 1'b0;
    reset_n = 1'b1;
    #1;
    check("post_rst_r3", dado_lido1, 32'h0);
    r1 = 5'd5; r2 = 5'd31; #1;
    check("rst_state_p1", dado_lido1, 32'h0);
    check("rst_state_p2", dado_lido2, 32'h0);

    // Basic write then read on both ports.
    wr(5'd5, 32'hDEAD_BEEF);
    r1 = 5'd5; r2 = 5'd5; #1;
    check("wr5_p1", dado_lido1, 32'hDEAD_BEEF);
    check("wr5_p2", dado_lido2, 32'hDEAD_BEEF);

    // Register 0 discards writes.
    wr(5'd0, 32'hFFFF_FFFF);
    r1 = 5'd0; r2 = 5'd0; #1;
    check("reg0_p1", dado_lido1, 32'h0);
    check("reg0_p2", dado_lido2, 32'h0);

    // RegWrite=0 holds state.
    RegWrite = 1'b0; r3 = 5'd7; dado_escrita = 32'h1234_5678;
    tick();
    r1 = 5'd7; #1;
    check("hold_r7", dado_lido1, 32'h0);

    // Distinct registers on the two ports, including the top index.
    wr(5'd31, 32'hCAFE_F00D);
    wr(5'd1, 32'h0000_0001);
    r1 = 5'd31; r2 = 5'd1; #1;
    check("top_p1", dado_lido1, 32'hCAFE_F00D);
    check("one_p2", dado_lido2, 32'h0000_0001);
    r1 = 5'd5; #1;
    check("wr5_kept", dado_lido1, 32'hDEAD_BEEF);

    // Same-cycle write and read of reg 9.
    wr(5'd9, 32'h0000_0011);
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'h0000_0022;
`else
    same_cycle_exp = 32'h0000_0011;
`endif
    RegWrite = 1'b1; r3 = 5'd9; r1 = 5'd9; r2 = 5'd9; dado_escrita = 32'h0000_0022; #1;
    check("same_cyc_p1", dado_lido1, same_cycle_exp);
    check("same_cyc_p2", dado_lido2, same_cycle_exp);
    r2 = 5'd5; #1;
    check("same_cyc_other", dado_lido2, 32'hDEAD_BEEF);
    tick();
    RegWrite = 1'b0; #1;
    check("after_edge_p1", dado_lido1, 32'h0000_0022);

    // Mid-cycle reset with a write pending: clears at once, no forwarding, reset wins at the edge.
    RegWrite = 1'b1; r3 = 5'd12; dado_escrita = 32'h0000_0055;
    r1 = 5'd12; r2 = 5'd5;
    #2;
    reset_n = 1'b0; #1;
    check("midrst_fwd_p1", dado_lido1, 32'h0);
    check("midrst_p2", dado_lido2, 32'h0);
    r1 = 5'd31; r2 = 5'd9; #1;
    check("midrst_r31", dado_lido1, 32'h0);
    check("midrst_r9", dado_lido2, 32'h0);
    tick();
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r1 = 5'(i); r2 = 5'(31 - i); #1;
      check("rst_sweep_p1", dado_lido1, 32'h0);
      check("rst_sweep_p2", dado_lido2, 32'h0);
    end
    reset_n = 1'b1;
    r1 = 5'd12; r2 = 5'd5; #1;
    check("rst_win_r12", dado_lido1, 32'h0);
    check("rst_clr_r5", dado_lido2, 32'h0);

    // Sign extender.
    ext_vecs[0] = '{16'h7FFF, 32'h0000_7FFF};
    ext_vecs[1] = '{16'h8000, 32'hFFFF_8000};
    ext_vecs[2] = '{16'hFFFF, 32'hFFFF_FFFF};
    ext_vecs[3] = '{16'h0000, 32'h0000_0000};
    ext_vecs[4] = '{16'h1234, 32'h0000_1234};
    foreach (ext_vecs[i]) begin
      sinal16 = ext_vecs[i].in; #1;
      check("sign_ext", sinal32, ext_vecs[i].exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
